// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_rx
// Description : Oversampling 8N1 serial receiver. Deserialises bytes LSB
//               first and writes each good byte into frame RAM at
//               (cycle << 2) + index. Raises full after BYTES good bytes and
//               holds it until the consumer acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_rx #(
    parameter int BYTES      = 4,
    parameter int OVERSAMPLE = 8,
    parameter int GAP_BITS   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_rx,
    input  logic       i_ack,
    input  logic [5:0] i_cycle,
    output logic [8:0] o_addr,
    output logic [7:0] o_wdata,
    output logic       o_we,
    output logic       o_full,
    output logic       o_frame_err,
    output logic [2:0] o_switch
);

    // Counter widths and compare points.
    localparam int c_CNT_W     = $clog2(OVERSAMPLE);
    localparam int c_GAP_LIMIT = GAP_BITS * OVERSAMPLE - 1;
    localparam int c_GAP_W     = $clog2(c_GAP_LIMIT + 2);

    // The edge detector adds one clock of latency, so the start decision
    // fires two counts early to land the sample near mid-bit.
    localparam logic [c_CNT_W-1:0] c_HALF_END = c_CNT_W'(OVERSAMPLE / 2 - 2);
    localparam logic [c_CNT_W-1:0] c_BIT_END  = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_END  = c_GAP_W'(c_GAP_LIMIT);
    localparam logic [2:0]         c_LAST_IDX = 3'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_WRITE  = 3'd4,
        S_RESYNC = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_rxs;
    logic                r_rxs_prev;
    logic [7:0]          r_shift;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_bits;
    logic [c_GAP_W-1:0]  r_gap;
    logic                w_fall;

    assign w_fall = r_rxs_prev & ~r_rxs;

    // Two-flop synchroniser for the asynchronous line plus one history flop
    // for falling-edge detection; runs regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= i_rx;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
        end
    end

    // Receive state machine with registered RAM-write and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'd0;
            r_cnt       <= '0;
            r_bits      <= 3'd0;
            r_gap       <= '0;
            o_addr      <= 9'd0;
            o_wdata     <= 8'd0;
            o_we        <= 1'b0;
            o_full      <= 1'b0;
            o_frame_err <= 1'b0;
            o_switch    <= 3'd0;
        end else begin
            o_we <= 1'b0;
            if (!i_en) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_bits   <= 3'd0;
                r_gap    <= '0;
                o_full   <= 1'b0;
                o_switch <= 3'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_fall) begin
                            r_cnt   <= '0;
                            r_bits  <= 3'd0;
                            r_gap   <= '0;
                            r_state <= S_START;
                        end else if (o_switch != 3'd0) begin
                            // A frame in progress must not stall forever.
                            if (r_gap == c_GAP_END) begin
                                r_gap       <= '0;
                                o_switch    <= 3'd0;
                                o_frame_err <= 1'b1;
                            end else begin
                                r_gap <= r_gap + c_GAP_W'(1);
                            end
                        end
                    end
                    S_START: begin
                        if (r_cnt == c_HALF_END) begin
                            r_cnt   <= '0;
                            r_state <= r_rxs ? S_IDLE : S_DATA;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (r_cnt == c_BIT_END) begin
                            r_cnt   <= '0;
                            r_shift <= {r_rxs, r_shift[7:1]};
                            if (r_bits == 3'd7) begin
                                r_state <= S_STOP;
                            end else begin
                                r_bits <= r_bits + 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (r_cnt == c_BIT_END) begin
                            r_cnt <= '0;
                            if (r_rxs) begin
                                // Registered here so the strobe lines up
                                // with the one-clock WRITE state.
                                o_we     <= 1'b1;
                                o_addr   <= {1'b0, i_cycle, 2'b00} + {6'd0, o_switch};
                                o_wdata  <= r_shift;
                                o_switch <= o_switch + 3'd1;
                                if (o_switch == c_LAST_IDX) begin
                                    o_full <= 1'b1;
                                end
                                r_state <= S_WRITE;
                            end else begin
                                o_frame_err <= 1'b1;
                                o_switch    <= 3'd0;
                                r_state     <= S_RESYNC;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    S_WRITE: begin
                        if (o_full) begin
                            // An ack coincident with full rising is honoured here.
                            if (i_ack) begin
                                o_full   <= 1'b0;
                                o_switch <= 3'd0;
                                r_state  <= S_IDLE;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_RESYNC: begin
                        if (r_rxs) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_DONE: begin
                        if (i_ack) begin
                            o_full   <= 1'b0;
                            o_switch <= 3'd0;
                            r_state  <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
            // Acknowledge clears the sticky error and wins over any set above.
            if (i_ack) begin
                o_frame_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_rx
// Description : Directed self-checking bench for uart_frame_rx (defaults:
//               BYTES=4, OVERSAMPLE=8, GAP_BITS=20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_rx;

    localparam int OS = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       i_en    = 1'b1;
    logic       i_rx    = 1'b1;
    logic       i_ack   = 1'b0;
    logic [5:0] i_cycle = 6'd0;
    logic [8:0] o_addr;
    logic [7:0] o_wdata;
    logic       o_we;
    logic       o_full;
    logic       o_frame_err;
    logic [2:0] o_switch;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [8:0] wa[$];
    logic [7:0] wd[$];
    logic       wf[$];
    int         we_while_full = 0;
    logic       full_q = 1'b0;

    uart_frame_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .i_rx       (i_rx),
        .i_ack      (i_ack),
        .i_cycle    (i_cycle),
        .o_addr     (o_addr),
        .o_wdata    (o_wdata),
        .o_we       (o_we),
        .o_full     (o_full),
        .o_frame_err(o_frame_err),
        .o_switch   (o_switch)
    );

    always #5 clk = ~clk;

    // Log every write strobe away from the active edge.
    always @(negedge clk) begin
        if (o_we) begin
            wa.push_back(o_addr);
            wd.push_back(o_wdata);
            wf.push_back(o_full);
            if (full_q) we_while_full++;
        end
        full_q = o_full;
    end

    task automatic bit_time(input logic v);
        i_rx = v;
        repeat (OS) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        wa.delete();
        wd.delete();
        wf.delete();
    endtask

    task automatic pulse_ack;
        i_ack = 1'b1;
        @(posedge clk);
        #1;
        i_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (o_addr !== 9'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", o_addr); end
        n_cmp++;
        if (o_wdata !== 8'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", o_wdata); end
        n_cmp++;
        if (o_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", o_we); end
        n_cmp++;
        if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", o_full); end
        n_cmp++;
        if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_frame_err); end
        n_cmp++;
        if (o_switch !== 3'd0) begin n_fail++; $display("FAIL reset_switch: got %0d want 0", o_switch); end
        n_cmp++;
        rst_n = 1'b1;
        idle(4);
        if (o_we !== 1'b0 || o_switch !== 3'd0) begin
            n_fail++; $display("FAIL post_reset_idle: we=%b switch=%0d want 0/0", o_we, o_switch);
        end
        n_cmp++;
    endtask

    task automatic test_good_frame;
        logic [7:0] exp_d [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        i_cycle = 6'd5;
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(exp_d[i], 1'b1);
        idle(4);
        if (wa.size() != 4) begin n_fail++; $display("FAIL good_count: got %0d want 4", wa.size()); end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                if (wa[i] !== 9'(20 + i)) begin n_fail++; $display("FAIL good_addr%0d: got %0d want %0d", i, wa[i], 20 + i); end
                n_cmp++;
                if (wd[i] !== exp_d[i]) begin n_fail++; $display("FAIL good_data%0d: got %h want %h", i, wd[i], exp_d[i]); end
                n_cmp++;
            end
        end
        if (wa.size() == 4) begin
            if (wf[3] !== 1'b1 || wf[2] !== 1'b0) begin
                n_fail++; $display("FAIL good_full_with_we: got %b%b want 01", wf[2], wf[3]);
            end
            n_cmp++;
        end
        if (o_full !== 1'b1) begin n_fail++; $display("FAIL good_full_held: got %b want 1", o_full); end
        n_cmp++;
        pulse_ack();
        idle(2);
        if (o_full !== 1'b0) begin n_fail++; $display("FAIL good_ack_full: got %b want 0", o_full); end
        n_cmp++;
        if (o_switch !== 3'd0) begin n_fail++; $display("FAIL good_ack_switch: got %0d want 0", o_switch); end
        n_cmp++;
    endtask

    task automatic test_start_glitch;
        clear_log();
        i_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(30);
        if (wa.size() != 0) begin n_fail++; $display("FAIL glitch_we: got %0d writes want 0", wa.size()); end
        n_cmp++;
        if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_err: got %b want 0", o_frame_err); end
        n_cmp++;
        if (o_switch !== 3'd0) begin n_fail++; $display("FAIL glitch_switch: got %0d want 0", o_switch); end
        n_cmp++;
    endtask

    task automatic test_bad_stop;
        logic [7:0] exp_d [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        i_cycle = 6'd2;
        clear_log();
        send_byte(8'h12, 1'b1);
        if (o_switch !== 3'd1) begin n_fail++; $display("FAIL badstop_first_switch: got %0d want 1", o_switch); end
        n_cmp++;
        if (wa.size() != 1 || wa[0] !== 9'd8 || wd[0] !== 8'h12) begin
            n_fail++; $display("FAIL badstop_first_write: count %0d want 1 at addr 8 data 12", wa.size());
        end
        n_cmp++;
        send_byte(8'h55, 1'b0);
        repeat (24) @(posedge clk);
        #1;
        if (wa.size() != 1) begin n_fail++; $display("FAIL badstop_no_we: got %0d writes want 1", wa.size()); end
        n_cmp++;
        if (o_frame_err !== 1'b1) begin n_fail++; $display("FAIL badstop_err: got %b want 1", o_frame_err); end
        n_cmp++;
        if (o_switch !== 3'd0) begin n_fail++; $display("FAIL badstop_switch: got %0d want 0", o_switch); end
        n_cmp++;
        idle(10);
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(exp_d[i], 1'b1);
        idle(4);
        if (wa.size() != 4) begin n_fail++; $display("FAIL resume_count: got %0d want 4", wa.size()); end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                if (wa[i] !== 9'(8 + i) || wd[i] !== exp_d[i]) begin
                    n_fail++; $display("FAIL resume_write%0d: got %0d/%h want %0d/%h", i, wa[i], wd[i], 8 + i, exp_d[i]);
                end
                n_cmp++;
            end
        end
        if (o_frame_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", o_frame_err); end
        n_cmp++;
        pulse_ack();
        idle(2);
        if (o_frame_err !== 1'b0 || o_full !== 1'b0) begin
            n_fail++; $display("FAIL badstop_ack: err=%b full=%b want 0/0", o_frame_err, o_full);
        end
        n_cmp++;
    endtask

    task automatic test_gap_timeout;
        i_cycle = 6'd1;
        clear_log();
        send_byte(8'h9A, 1'b1);
        send_byte(8'hBC, 1'b1);
        idle(100);
        if (o_switch !== 3'd2 || o_frame_err !== 1'b0) begin
            n_fail++; $display("FAIL gap_early: switch=%0d err=%b want 2/0", o_switch, o_frame_err);
        end
        n_cmp++;
        if (wa.size() != 2 || wa[0] !== 9'd4 || wa[1] !== 9'd5 || wd[0] !== 8'h9A || wd[1] !== 8'hBC) begin
            n_fail++; $display("FAIL gap_writes: count %0d want 2 at 4,5 data 9A,BC", wa.size());
        end
        n_cmp++;
        idle(80);
        if (o_frame_err !== 1'b1) begin n_fail++; $display("FAIL gap_err: got %b want 1", o_frame_err); end
        n_cmp++;
        if (o_switch !== 3'd0) begin n_fail++; $display("FAIL gap_switch: got %0d want 0", o_switch); end
        n_cmp++;
        if (o_full !== 1'b0) begin n_fail++; $display("FAIL gap_full: got %b want 0", o_full); end
        n_cmp++;
        pulse_ack();
        idle(2);
        if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL gap_ack_err: got %b want 0", o_frame_err); end
        n_cmp++;
    endtask

    task automatic test_overrun_ack;
        logic [7:0] fa [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        logic [7:0] fb [4] = '{8'h81, 8'h82, 8'h83, 8'h84};
        i_cycle = 6'd3;
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(fa[i], 1'b1);
        idle(2);
        if (o_full !== 1'b1 || wa.size() != 4) begin
            n_fail++; $display("FAIL overrun_setup: full=%b writes=%0d want 1/4", o_full, wa.size());
        end
        n_cmp++;
        send_byte(8'h77, 1'b1);
        idle(4);
        if (wa.size() != 4) begin n_fail++; $display("FAIL overrun_no_we: got %0d writes want 4", wa.size()); end
        n_cmp++;
        if (we_while_full != 0) begin n_fail++; $display("FAIL overrun_we_full: got %0d want 0", we_while_full); end
        n_cmp++;
        if (o_full !== 1'b1) begin n_fail++; $display("FAIL overrun_full_held: got %b want 1", o_full); end
        n_cmp++;
        pulse_ack();
        idle(2);
        if (o_full !== 1'b0) begin n_fail++; $display("FAIL overrun_ack: got %b want 0", o_full); end
        n_cmp++;
        i_cycle = 6'd4;
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(fb[i], 1'b1);
        idle(4);
        if (wa.size() != 4) begin n_fail++; $display("FAIL after_ack_count: got %0d want 4", wa.size()); end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                if (wa[i] !== 9'(16 + i) || wd[i] !== fb[i]) begin
                    n_fail++; $display("FAIL after_ack_write%0d: got %0d/%h want %0d/%h", i, wa[i], wd[i], 16 + i, fb[i]);
                end
                n_cmp++;
            end
        end
        pulse_ack();
        idle(2);
    endtask

    task automatic test_reset_mid;
        logic [7:0] b = 8'hA5;
        logic [7:0] fc [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        i_cycle = 6'd6;
        send_byte(8'h66, 1'b0);
        idle(10);
        send_byte(8'h99, 1'b1);
        if (o_frame_err !== 1'b1 || o_switch !== 3'd1) begin
            n_fail++; $display("FAIL rstmid_setup: err=%b switch=%0d want 1/1", o_frame_err, o_switch);
        end
        n_cmp++;
        clear_log();
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(b[i]);
        i_rx = b[4];
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        if (o_addr !== 9'd0 || o_wdata !== 8'd0 || o_we !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_bus: addr=%0d wdata=%h we=%b want 0/00/0", o_addr, o_wdata, o_we);
        end
        n_cmp++;
        if (o_full !== 1'b0 || o_frame_err !== 1'b0 || o_switch !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_status: full=%b err=%b switch=%0d want 0/0/0", o_full, o_frame_err, o_switch);
        end
        n_cmp++;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 5; i < 8; i++) bit_time(b[i]);
        bit_time(1'b1);
        rst_n = 1'b1;
        idle(10);
        if (wa.size() != 0) begin n_fail++; $display("FAIL rstmid_partial: got %0d writes want 0", wa.size()); end
        n_cmp++;
        for (int i = 0; i < 4; i++) send_byte(fc[i], 1'b1);
        idle(4);
        if (wa.size() != 4) begin n_fail++; $display("FAIL rstmid_frame_count: got %0d want 4", wa.size()); end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                if (wa[i] !== 9'(24 + i) || wd[i] !== fc[i]) begin
                    n_fail++; $display("FAIL rstmid_write%0d: got %0d/%h want %0d/%h", i, wa[i], wd[i], 24 + i, fc[i]);
                end
                n_cmp++;
            end
        end
        if (o_full !== 1'b1) begin n_fail++; $display("FAIL rstmid_full: got %b want 1", o_full); end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_start_glitch();
        test_bad_stop();
        test_gap_timeout();
        test_overrun_ack();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_rx.md
# uart_frame_rx

Serial receiver at the far end of the RS485 link driven by the frame transmitter. It oversamples the `rx` line and deserialises 8N1 bytes, LSB first. Each byte is written into frame RAM at `(cycle << 2) + index`. After `BYTES` good bytes it raises `full` and holds it until the consumer acknowledges.

## Interface
- `BYTES`, default 4: bytes per frame. Legal range 1..8.
- `OVERSAMPLE`, default 8: `clk` cycles per bit. Must be even and ≥4.
- `GAP_BITS`, default 20: inter-byte idle timeout, in bit times.

- `clk` in 1: single clock, `OVERSAMPLE` × baud.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: listen enable. Low forces idle.
- `rx` in 1: serial line, idle high, asynchronous.
- `ack` in 1: consumer acknowledge, synchronous to `clk`. Clears `full`.
- `cycle` in 6: frame slot. Sampled at every write.
- `addr` out 9: RAM write address.
- `wdata` out 8: RAM write data.
- `we` out 1: one-clock write strobe.
- `full` out 1: frame complete, held until `ack`.
- `frameErr` out 1: sticky error flag.
- `switch` out 3: index of the next byte in the frame.

## Operation
- Reset values: `addr`=0, `wdata`=0, `we`=0, `full`=0, `frameErr`=0, `switch`=0, state IDLE.
  - Both synchroniser flops reset to 1.
  - Shift register and counters reset to 0.
- `rx` passes through a 2-FF synchroniser. All logic uses the synchronised value `rxs`. The previous `rxs` is kept for edge detection.
- States: IDLE, START, DATA, STOP, WRITE, RESYNC, DONE.
- IDLE:
  - On a falling edge of `rxs` (prev 1, now 0), clear the bit counter and go to START.
  - While `switch`≠0, the gap counter increments every clock. It is cleared on leaving IDLE.
  - When the gap counter reaches `GAP_BITS`·`OVERSAMPLE`−1: `switch`←0, `frameErr`←1, remain in IDLE.
- START:
  - Count `OVERSAMPLE`/2 clocks and sample `rxs`.
  - If 0: clear the counter and go to DATA.
  - If 1: glitch. Return to IDLE with no error.
- DATA:
  - Every `OVERSAMPLE` clocks, sample `rxs` into the shift register: shift right, new bit enters at bit 7.
  - After 8 samples go to STOP.
- STOP: after `OVERSAMPLE` clocks, sample `rxs`.
  - If 1: go to WRITE.
  - If 0: `frameErr`←1, `switch`←0, go to RESYNC.
- RESYNC: wait until `rxs`=1, then go to IDLE.
- WRITE (one clock):
  - `addr` ← {1'b0,`cycle`,2'b00} + `switch`, modulo 512.
  - `wdata` ← shift register.
  - `we`=1.
  - `switch` ← `switch`+1.
  - If `switch` was `BYTES`−1: `full`←1 and go to DONE. Otherwise go to IDLE.
  - With `BYTES`>4, adjacent slots overlap. This is intended.
- DONE:
  - Incoming start bits are ignored and no writes occur.
  - On `ack`=1: `full`←0, `switch`←0, go to IDLE.
  - If `ack` is high on the clock `full` rises, it is honoured on the next clock.
- `frameErr`:
  - Set by stop-bit error or gap timeout.
  - Cleared only by `ack` or reset.
  - Clearing takes precedence over a simultaneous set.
- `en`=0: synchronous return to IDLE. `switch`←0, `we`←0, `full`←0. `frameErr` is held. The synchroniser keeps running.
- Reset asserted mid-byte: immediate return to reset values. The partial byte is never written.

## Timing
- The start bit is sampled 2 + `OVERSAMPLE`/2 clocks after the `rx` pin falls.
- Data bit k (k = 0..7) is sampled `OVERSAMPLE`·(k+1) clocks after the start sample.
- `we` is high exactly one clock, on the clock after the stop-bit sample. `addr` and `wdata` are valid in that same cycle.
- `full` rises in the same cycle as the last `we`.
- The receiver is back in IDLE one clock after a good stop sample. It accepts back-to-back bytes with a single stop bit.
- `we` is never asserted while `full`=1.

## Test plan
- **Good frame:** `cycle`=5; send bytes 0xA5, 0x3C, 0xFF, 0x00 back-to-back at `OVERSAMPLE`=8. Expect four `we` pulses at `addr` 20, 21, 22, 23 with matching data. `full`=1 with the last write; `ack` pulse gives `full`=0, `switch`=0.
- **Start glitch:** drive `rx` low for 3 clocks. Expect no `we`, `frameErr`=0, back in IDLE.
- **Bad stop bit:** send 0x55 with stop bit 0 after one good byte. Expect no second `we`, `frameErr`=1, `switch`=0, no progress until `rx` returns high. A following 4-byte frame then writes from index 0.
- **Gap timeout:** send 2 bytes, then idle for `GAP_BITS`·8 clocks. Expect `frameErr`=1, `switch`=0, and `full` never set.
- **Overrun/ack:** while `full`=1, send byte 0x77. Expect no `we`. After `ack`, the next frame is stored normally.
- **Reset mid-byte:** assert `reset` during data bit 4. Expect all outputs at reset values immediately. After release, a full frame is received correctly.
